cpu_ctrl_fsm: RTL
=================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle controller that sequences the register-file/shifter/ALU datapath through one instruction at a time.
- Holds the instruction register and decodes fields.
- Drives datapath load/select/write strobes and the ALU opcode.
- Handshakes with the top level through start (s) and wait (w); sits between the instruction source and the datapath.

Parameters:
- IW, 16, instruction width (field positions below assume 16)
- RW, 3, register-number width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s  in  1  start: begin executing the held instruction
- load  in  1  capture in into instruction register
- in  in  IW  instruction word
- w  out  1  controller idle, ready for s
- err  out  1  last started instruction was illegal
- readnum  out  RW  register-file read select
- writenum  out  RW  register-file write select
- write  out  1  register-file write enable
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status flags (Z, N, V)
- asel  out  1  1 forces ALU A input to 0
- bsel  out  1  1 selects sign-extended imm5 for B
- vsel  out  2  write-back source: 00 C, 01 sximm8, 10 PC (reserved), 11 mdata (reserved)
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- shift  out  2  shifter control, IR[4:3]
- sximm8  out  16  sign-extended IR[7:0]
- sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Legal encodings:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN
  - All other encodings are illegal.
- Reset (async, rst_n=0): state WAIT, IR=0, err=0, w=1; all strobes 0, all selects 0.
- load is honoured only in WAIT; ignored in all other states. If load and s are asserted together in WAIT, IR captures in and DECODE uses the new IR.
- s is ignored outside WAIT.
- Outputs are Moore, decoded from state and IR. Strobes are single-cycle.
- States and transitions:
  - WAIT: w=1.
    - s=1 -> DECODE; err clears on this transition.
  - DECODE: no strobes.
    - MOV imm -> WIMM
    - MOV reg or MVN -> GETB
    - ADD/CMP/AND -> GETA
    - illegal -> WAIT, set err
  - GETA: readnum=Rn, loada=1 -> GETB.
  - GETB: readnum=Rm, loadb=1 -> EXEC.
  - EXEC: loadc=1, ALUop=op, shift=sh, bsel=0.
    - MOV reg: ALUop=00, asel=1.
    - MVN: ALUop=11.
    - CMP: loadc=0, loads=1 -> WAIT.
    - all others -> WREG.
  - WREG: write=1, writenum=Rd, vsel=00 -> WAIT.
  - WIMM: write=1, writenum=Rn, vsel=01 -> WAIT.
- Latency, counted as cycles from the edge sampling s to the edge returning to WAIT:
  - MOV imm: 2
  - MOV reg / MVN: 4
  - CMP: 4
  - ADD / AND: 5
  - illegal: 1
- readnum holds its last driven value in states that do not drive it; it has no effect in those states.
- Reset mid-instruction aborts immediately with no further strobes; IR clears.
- The controller does not observe ALU overflow; overflow is captured only via loads in CMP.

Decomposition:
- cpu_pkg holds:
  - state enum (WAIT, DECODE, GETA, GETB, EXEC, WREG, WIMM)
  - opcode/op constants
  - ALUop constants
  - vsel encodings
  - IR field position localparams
- One sub-module, instr_decoder (combinational): IR -> fields, sximm8, sximm5, legal/class flags.

Test Plan:
- Reset then load=1,in=16'hD207 (MOV R2,#7), s=1 -> DECODE, WIMM; in WIMM write=1, writenum=2, vsel=01, sximm8=16'h0007; w=1 two cycles after s.
- in=16'hA0E2 (ADD R7,R0,R2, no shift) -> GETA readnum=0 loada; GETB readnum=2 loadb; EXEC ALUop=00 loadc; WREG writenum=7 write; w returns after 5 cycles.
- in=16'hA902 (CMP R1,R2) -> EXEC loads=1, loadc=0, ALUop=01; no write ever asserted; back to WAIT after 4 cycles.
- in=16'hB860 (MVN R3,R0) -> skips GETA; EXEC ALUop=11; WREG writenum=3; C=~B when driven into a real ALU.
- in=16'hE000 (illegal), s=1 -> WAIT after 1 cycle with err=1; next legal s clears err.
- Mid-ADD (state GETB) assert rst_n=0 -> all strobes 0 asynchronously, w=1, IR=0; load asserted during EXEC leaves IR unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU controller:
// state encoding, instruction field positions, opcode/op, ALU and write-back encodings.
package cpu_pkg;

    localparam int unsigned IW     = 16;
    localparam int unsigned RW     = 3;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned SH_W   = 2;
    localparam int unsigned IMM8_W = 8;
    localparam int unsigned IMM5_W = 5;

    localparam int unsigned IR_OPC_LSB = 13;
    localparam int unsigned IR_OP_LSB  = 11;
    localparam int unsigned IR_RN_LSB  = 8;
    localparam int unsigned IR_RD_LSB  = 5;
    localparam int unsigned IR_SH_LSB  = 3;
    localparam int unsigned IR_RM_LSB  = 0;

    localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

    localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
    localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
    localparam logic [OP_W-1:0] OP_AND     = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GETA   = 3'd2,
        S_GETB   = 3'd3,
        S_EXEC   = 3'd4,
        S_WREG   = 3'd5,
        S_WIMM   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_e;

    // PC and MDATA sources are reserved for later instruction classes
    typedef enum logic [1:0] {
        VSEL_C     = 2'b00,
        VSEL_IMM8  = 2'b01,
        VSEL_PC    = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RW-1:0]   rn;
        logic [RW-1:0]   rd;
        logic [SH_W-1:0] sh;
        logic [RW-1:0]   rm;
        logic [IW-1:0]   sximm8;
        logic [IW-1:0]   sximm5;
        logic            mov_imm;
        logic            mov_reg;
        logic            mvn;
        logic            alu_rn;
        logic            cmp;
    } dec_t;

endpackage

// File: rtl/cpu_ctrl_fsm_instr_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift fields,
// sign-extends the immediates and classifies the encoding.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [IW-1:0] i_ir,
    output dec_t          o_dec_c
);

    logic [OPC_W-1:0] w_opc;
    logic [OP_W-1:0]  w_op;

    assign w_opc = i_ir[IR_OPC_LSB +: OPC_W];
    assign w_op  = i_ir[IR_OP_LSB +: OP_W];

    always_comb begin
        o_dec_c         = '0;
        o_dec_c.op      = w_op;
        o_dec_c.rn      = i_ir[IR_RN_LSB +: RW];
        o_dec_c.rd      = i_ir[IR_RD_LSB +: RW];
        o_dec_c.sh      = i_ir[IR_SH_LSB +: SH_W];
        o_dec_c.rm      = i_ir[IR_RM_LSB +: RW];
        o_dec_c.sximm8  = {{(IW-IMM8_W){i_ir[IMM8_W-1]}}, i_ir[IMM8_W-1:0]};
        o_dec_c.sximm5  = {{(IW-IMM5_W){i_ir[IMM5_W-1]}}, i_ir[IMM5_W-1:0]};
        o_dec_c.mov_imm = (w_opc == OPC_MOV) && (w_op == OP_MOV_IMM);
        o_dec_c.mov_reg = (w_opc == OPC_MOV) && (w_op == OP_MOV_REG);
        o_dec_c.mvn     = (w_opc == OPC_ALU) && (w_op == OP_MVN);
        o_dec_c.cmp     = (w_opc == OPC_ALU) && (w_op == OP_CMP);
        o_dec_c.alu_rn  = (w_opc == OPC_ALU) &&
                          ((w_op == OP_ADD) || (w_op == OP_CMP) || (w_op == OP_AND));
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: holds the instruction register and sequences the
// register-file/shifter/ALU datapath one instruction at a time.
module cpu_ctrl_fsm
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s,
    input  logic          load,
    input  logic [IW-1:0] in,
    output logic          w,
    output logic          err,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [IW-1:0] sximm8,
    output logic [IW-1:0] sximm5
);

    state_e          r_state, w_state_nxt;
    logic [IW-1:0]   r_ir, w_ir_nxt;
    dec_t            w_dec;

    logic            r_w, w_w_nxt;
    logic            r_err, w_err_nxt;
    logic [RW-1:0]   r_readnum, w_readnum_nxt;
    logic [RW-1:0]   r_writenum, w_writenum_nxt;
    logic            r_write, w_write_nxt;
    logic            r_loada, w_loada_nxt;
    logic            r_loadb, w_loadb_nxt;
    logic            r_loadc, w_loadc_nxt;
    logic            r_loads, w_loads_nxt;
    logic            r_asel, w_asel_nxt;
    vsel_e           r_vsel, w_vsel_nxt;
    alu_e            r_aluop, w_aluop_nxt;
    logic [SH_W-1:0] r_shift, w_shift_nxt;
    logic [IW-1:0]   r_sximm8, r_sximm5;

    // The IR only changes in WAIT, so decoding the next IR also serves DECODE
    assign w_ir_nxt = ((r_state == S_WAIT) && load) ? in : r_ir;

    instr_decoder u_dec (
        .i_ir    (w_ir_nxt),
        .o_dec_c (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT;
            r_ir       <= '0;
            r_w        <= 1'b1;
            r_err      <= 1'b0;
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_asel     <= 1'b0;
            r_vsel     <= VSEL_C;
            r_aluop    <= ALU_ADD;
            r_shift    <= '0;
            r_sximm8   <= '0;
            r_sximm5   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir       <= w_ir_nxt;
            r_w        <= w_w_nxt;
            r_err      <= w_err_nxt;
            r_readnum  <= w_readnum_nxt;
            r_writenum <= w_writenum_nxt;
            r_write    <= w_write_nxt;
            r_loada    <= w_loada_nxt;
            r_loadb    <= w_loadb_nxt;
            r_loadc    <= w_loadc_nxt;
            r_loads    <= w_loads_nxt;
            r_asel     <= w_asel_nxt;
            r_vsel     <= w_vsel_nxt;
            r_aluop    <= w_aluop_nxt;
            r_shift    <= w_shift_nxt;
            r_sximm8   <= w_dec.sximm8;
            r_sximm5   <= w_dec.sximm5;
        end
    end

    // Next state, then the Moore outputs of that state so they land registered
    always_comb begin
        w_state_nxt    = r_state;
        w_err_nxt      = r_err;
        w_readnum_nxt  = r_readnum;
        w_w_nxt        = 1'b0;
        w_writenum_nxt = '0;
        w_write_nxt    = 1'b0;
        w_loada_nxt    = 1'b0;
        w_loadb_nxt    = 1'b0;
        w_loadc_nxt    = 1'b0;
        w_loads_nxt    = 1'b0;
        w_asel_nxt     = 1'b0;
        w_vsel_nxt     = VSEL_C;
        w_aluop_nxt    = ALU_ADD;
        w_shift_nxt    = '0;

        case (r_state)
            S_WAIT: begin
                if (s) begin
                    w_state_nxt = S_DECODE;
                    w_err_nxt   = 1'b0;
                end
            end
            S_DECODE: begin
                if (w_dec.mov_imm) begin
                    w_state_nxt = S_WIMM;
                end else if (w_dec.mov_reg || w_dec.mvn) begin
                    w_state_nxt = S_GETB;
                end else if (w_dec.alu_rn) begin
                    w_state_nxt = S_GETA;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_err_nxt   = 1'b1;
                end
            end
            S_GETA:  w_state_nxt = S_GETB;
            S_GETB:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_dec.cmp ? S_WAIT : S_WREG;
            S_WREG:  w_state_nxt = S_WAIT;
            S_WIMM:  w_state_nxt = S_WAIT;
            default: w_state_nxt = S_WAIT;
        endcase

        case (w_state_nxt)
            S_WAIT: w_w_nxt = 1'b1;
            S_GETA: begin
                w_readnum_nxt = w_dec.rn;
                w_loada_nxt   = 1'b1;
            end
            S_GETB: begin
                w_readnum_nxt = w_dec.rm;
                w_loadb_nxt   = 1'b1;
            end
            S_EXEC: begin
                w_aluop_nxt = w_dec.mov_reg ? ALU_ADD : alu_e'(w_dec.op);
                w_shift_nxt = w_dec.sh;
                w_asel_nxt  = w_dec.mov_reg;
                w_loads_nxt = w_dec.cmp;
                w_loadc_nxt = !w_dec.cmp;
            end
            S_WREG: begin
                w_write_nxt    = 1'b1;
                w_writenum_nxt = w_dec.rd;
                w_vsel_nxt     = VSEL_C;
            end
            S_WIMM: begin
                w_write_nxt    = 1'b1;
                w_writenum_nxt = w_dec.rn;
                w_vsel_nxt     = VSEL_IMM8;
            end
            default: ;
        endcase
    end

    assign w        = r_w;
    assign err      = r_err;
    assign readnum  = r_readnum;
    assign writenum = r_writenum;
    assign write    = r_write;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign asel     = r_asel;
    assign bsel     = 1'b0;
    assign vsel     = r_vsel;
    assign ALUop    = r_aluop;
    assign shift    = r_shift;
    assign sximm8   = r_sximm8;
    assign sximm5   = r_sximm5;

endmodule
